// File: rtl/chan_stream_pkg.sv
// chan_stream_pkg: shared widths and types for the channel stream unpacker
package chan_stream_pkg;
   localparam int CHAN_W         = 64;
   localparam int LANE_W_DEFAULT = 16;
   localparam int CNT_W_DEFAULT  = 32;
   // wide enough for any lane split of a 64-bit channel word, down to 1-bit lanes
   typedef logic [5:0]               lane_idx_t;
   typedef logic [CNT_W_DEFAULT-1:0] cnt_t;
endpackage

// File: rtl/chan_stream_unpacker_fifo.sv
// chan_fifo2: 2-deep FIFO whose ready output is registered as "not full"
module chan_fifo2 #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_wr,
   input  logic [W-1:0] i_data,
   input  logic         i_rd,
   output logic         o_ready,
   output logic [W-1:0] o_head,
   output logic [1:0]   o_count
);
   logic [W-1:0] r_mem [2];
   logic         r_wp;
   logic         r_rp;
   logic [1:0]   r_cnt;
   logic         r_ready;
   logic [1:0]   w_cnt_nxt;

   assign w_cnt_nxt = r_cnt + {1'b0, i_wr} - {1'b0, i_rd};
   assign o_ready   = r_ready;
   assign o_head    = r_mem[r_rp];
   assign o_count   = r_cnt;

   // storage, pointers, occupancy and the look-ahead ready flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wp     <= 1'b0;
         r_rp     <= 1'b0;
         r_cnt    <= 2'd0;
         r_ready  <= 1'b0;
      end else begin
         if (i_wr) begin
            r_mem[r_wp] <= i_data;
            r_wp        <= ~r_wp;
         end
         if (i_rd) r_rp <= ~r_rp;
         r_cnt   <= w_cnt_nxt;
         r_ready <= (w_cnt_nxt != 2'd2);
      end
   end
endmodule

// File: rtl/chan_stream_unpacker.sv
// chan_stream_unpacker: buffers channel words and emits them as narrow lanes, LSB lane first
module chan_stream_unpacker
   import chan_stream_pkg::*;
#(
   parameter int IN_W   = CHAN_W,
   parameter int LANE_W = LANE_W_DEFAULT,
   parameter int CNT_W  = CNT_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [IN_W-1:0]   snk_data,
   input  logic              snk_valid,
   output logic              snk_ready,
   output logic [LANE_W-1:0] src_data,
   output logic              src_valid,
   input  logic              src_ready,
   output logic              src_sop,
   output logic              src_eop,
   input  logic              clr_counts,
   output logic [CNT_W-1:0]  words_in,
   output logic [CNT_W-1:0]  lanes_out,
   output logic              busy
);
   localparam int        NLANES = IN_W / LANE_W;
   localparam lane_idx_t LAST   = lane_idx_t'(NLANES - 1);

   logic [IN_W-1:0]   w_head;
   logic [1:0]        w_count;
   logic              w_wr;
   logic              w_load;
   logic              w_fill;
   logic              w_pop;
   lane_idx_t         r_lane;
   logic [LANE_W-1:0] r_src_data;
   logic              r_src_valid;
   logic              r_src_sop;
   logic              r_src_eop;
   logic [CNT_W-1:0]  r_words_in;
   logic [CNT_W-1:0]  r_lanes_out;

   assign w_wr   = snk_valid && snk_ready;
   assign w_load = !r_src_valid || src_ready;
   assign w_fill = w_load && (w_count != 2'd0);
   assign w_pop  = w_fill && (r_lane == LAST);

   chan_fifo2 #(.W(IN_W)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_wr    (w_wr),
      .i_data  (snk_data),
      .i_rd    (w_pop),
      .o_ready (snk_ready),
      .o_head  (w_head),
      .o_count (w_count)
   );

   // output register: take the next lane of the head word whenever the slot is free or being accepted
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lane      <= '0;
         r_src_data  <= '0;
         r_src_valid <= 1'b0;
         r_src_sop   <= 1'b0;
         r_src_eop   <= 1'b0;
      end else if (w_load) begin
         r_src_valid <= w_fill;
         if (w_fill) begin
            r_src_data <= w_head[r_lane*LANE_W +: LANE_W];
            r_src_sop  <= (r_lane == '0);
            r_src_eop  <= (r_lane == LAST);
            r_lane     <= (r_lane == LAST) ? '0 : r_lane + 1'b1;
         end
      end
   end

   // status counters; a clear beats a same-cycle increment
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_words_in  <= '0;
         r_lanes_out <= '0;
      end else begin
         r_words_in  <= clr_counts ? '0 : r_words_in + CNT_W'(w_wr);
         r_lanes_out <= clr_counts ? '0 : r_lanes_out + CNT_W'(r_src_valid && src_ready);
      end
   end

   assign src_data  = r_src_data;
   assign src_valid = r_src_valid;
   assign src_sop   = r_src_sop;
   assign src_eop   = r_src_eop;
   assign words_in  = r_words_in;
   assign lanes_out = r_lanes_out;
   assign busy      = (w_count != 2'd0) || r_src_valid;
endmodule

// File: tb/tb_chan_stream_unpacker.sv
// tb_chan_stream_unpacker: directed and random checks of the unpacker against a lane-queue model
module tb_chan_stream_unpacker;
   import chan_stream_pkg::*;

   typedef struct {
      logic [15:0] d;
      logic        s;
      logic        e;
   } lane_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] snk_data;
   logic        snk_valid;
   logic        snk_ready, snk_ready_s;
   logic [15:0] src_data, src_data_s;
   logic        src_valid, src_valid_s;
   logic        src_ready;
   logic        src_sop, src_sop_s, src_eop, src_eop_s;
   logic        clr_counts;
   logic [31:0] words_in, lanes_out;
   logic [2:0]  words_in_s, lanes_out_s;
   logic        busy, busy_s;

   int    errors = 0;
   int    checks = 0;
   lane_t exp_q[$];
   cnt_t  m_words, m_lanes;
   logic  last_in, last_out;
   logic  hold;
   logic [15:0] hd;
   logic  hs, he;
   int    sent, got, g, bub, lowr;

   chan_stream_unpacker u_dut (
      .clk(clk), .reset_n(reset_n), .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready), .src_sop(src_sop), .src_eop(src_eop),
      .clr_counts(clr_counts), .words_in(words_in), .lanes_out(lanes_out), .busy(busy)
   );

   chan_stream_unpacker #(.CNT_W(3)) u_small (
      .clk(clk), .reset_n(reset_n), .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready_s),
      .src_data(src_data_s), .src_valid(src_valid_s), .src_ready(src_ready), .src_sop(src_sop_s), .src_eop(src_eop_s),
      .clr_counts(clr_counts), .words_in(words_in_s), .lanes_out(lanes_out_s), .busy(busy_s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock: score handshakes seen now, let the edge happen, then check what followed
   task automatic step();
      lane_t e;
      logic [63:0] w;
      last_in  = snk_valid && snk_ready;
      last_out = src_valid && src_ready;
      if (last_out) begin
         if (exp_q.size() == 0) chk("spurious lane", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("lane data", src_data, e.d);
            chk("lane sop", src_sop, e.s);
            chk("lane eop", src_eop, e.e);
         end
      end
      hold = src_valid && !src_ready;
      hd = src_data; hs = src_sop; he = src_eop;
      if (last_in) begin
         w = snk_data;
         for (int i = 0; i < 4; i++) exp_q.push_back('{w[i*16 +: 16], i == 0, i == 3});
      end
      m_words = clr_counts ? '0 : m_words + cnt_t'(last_in);
      m_lanes = clr_counts ? '0 : m_lanes + cnt_t'(last_out);
      @(negedge clk);
      if (hold) begin
         chk("stall valid", src_valid, 1);
         chk("stall data", src_data, hd);
         chk("stall sop", src_sop, hs);
         chk("stall eop", src_eop, he);
      end
      chk("words_in", words_in, m_words);
      chk("lanes_out", lanes_out, m_lanes);
      chk("words_in small", words_in_s, m_words[2:0]);
      chk("lanes_out small", lanes_out_s, m_lanes[2:0]);
      chk("busy", busy, exp_q.size() != 0);
   endtask

   task automatic drain(input int budget);
      snk_valid = 1'b0;
      g = 0;
      while (exp_q.size() != 0 && g < budget) begin
         step();
         g++;
      end
      chk("drained", exp_q.size(), 0);
   endtask

   task automatic clear();
      clr_counts = 1'b1;
      step();
      clr_counts = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; snk_data = '0; snk_valid = 1'b0; src_ready = 1'b0; clr_counts = 1'b0;
      m_words = '0; m_lanes = '0; hold = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst src_valid", src_valid, 0);
      chk("rst src_data", src_data, 0);
      chk("rst sop", src_sop, 0);
      chk("rst eop", src_eop, 0);
      chk("rst snk_ready", snk_ready, 0);
      chk("rst words_in", words_in, 0);
      chk("rst lanes_out", lanes_out, 0);
      chk("rst busy", busy, 0);
      reset_n = 1'b1;
      step();
      chk("ready after release", snk_ready, 1);

      // single word
      src_ready = 1'b1;
      snk_data = 64'h4444_3333_2222_1111;
      snk_valid = 1'b1;
      step();
      snk_valid = 1'b0;
      chk("t1 accept", last_in, 1);
      chk("t1 not yet valid", src_valid, 0);
      step();
      chk("t1 first valid", src_valid, 1);
      chk("t1 lane0", src_data, 16'h1111);
      chk("t1 sop", src_sop, 1);
      step(); chk("t1 lane1", src_data, 16'h2222);
      step(); chk("t1 lane2", src_data, 16'h3333);
      step(); chk("t1 lane3", src_data, 16'h4444);
      chk("t1 eop", src_eop, 1);
      step();
      chk("t1 idle", src_valid, 0);
      chk("t1 words", words_in, 1);
      chk("t1 lanes", lanes_out, 4);
      chk("t1 busy", busy, 0);

      // back-to-back stream of 8 words
      clear();
      sent = 0; got = 0; g = 0; bub = 0; lowr = 0;
      snk_valid = 1'b1; snk_data = {$urandom, $urandom};
      while (got < 32 && g < 200) begin
         if (!snk_ready && sent > 0 && sent < 8) lowr++;
         if (got > 0 && !src_valid) bub++;
         step(); g++;
         if (last_out) got++;
         if (last_in) begin
            sent++;
            if (sent == 8) snk_valid = 1'b0; else snk_data = {$urandom, $urandom};
         end
      end
      chk("t2 lanes", got, 32);
      chk("t2 bubbles", bub, 0);
      chk("t2 ready pulses", lowr > 0, 1);
      chk("t2 words", words_in, 8);
      chk("t2 lane count", lanes_out, 32);

      // output stall at lane 2 of word 0
      clear();
      sent = 0; g = 0;
      snk_data = 64'h4444_3333_2222_1111; snk_valid = 1'b1; src_ready = 1'b1;
      while (!(src_valid && src_data == 16'h3333) && g < 20) begin
         step(); g++;
         if (last_in) begin
            sent++;
            snk_data = 64'h9999_8888_7777_6666 + 64'(sent);
         end
      end
      chk("t3 reached lane2", src_valid && src_data == 16'h3333, 1);
      src_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t3 held 3333", src_data, 16'h3333);
         if (last_in) begin
            sent++;
            snk_data = 64'h9999_8888_7777_6666 + 64'(sent);
         end
      end
      chk("t3 fifo full", snk_ready, 0);
      src_ready = 1'b1;
      g = 0;
      while (sent < 3 && g < 40) begin
         step(); g++;
         if (last_in) begin
            sent++;
            snk_data = 64'h9999_8888_7777_6666 + 64'(sent);
         end
      end
      drain(100);
      chk("t3 lanes vs words", lanes_out, words_in * 4);

      // random traffic, 1000 words
      clear();
      sent = 0; g = 0;
      while (sent < 1000 && g < 30000) begin
         snk_valid = 1'($urandom);
         snk_data = {$urandom, $urandom};
         src_ready = 1'($urandom);
         step(); g++;
         if (last_in) sent++;
      end
      snk_valid = 1'b0;
      g = 0;
      while (exp_q.size() != 0 && g < 20000) begin
         src_ready = 1'($urandom);
         step(); g++;
      end
      chk("t4 drained", exp_q.size(), 0);
      chk("t4 words", words_in, 1000);
      chk("t4 lanes vs words", lanes_out, words_in * 4);

      // reset in the middle of a word
      src_ready = 1'b1;
      snk_data = 64'h1234_5678_9ABC_DEF0; snk_valid = 1'b1;
      step();
      snk_valid = 1'b0;
      g = 0;
      while (!(src_valid && src_data == 16'h9ABC) && g < 10) begin
         step(); g++;
      end
      chk("t5 at lane1", src_data, 16'h9ABC);
      #2 reset_n = 1'b0;
      #1;
      chk("t5 async valid", src_valid, 0);
      chk("t5 async data", src_data, 0);
      chk("t5 async sop", src_sop, 0);
      chk("t5 async eop", src_eop, 0);
      chk("t5 async ready", snk_ready, 0);
      chk("t5 async words", words_in, 0);
      chk("t5 async lanes", lanes_out, 0);
      chk("t5 async busy", busy, 0);
      exp_q.delete(); m_words = '0; m_lanes = '0; hold = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      step();
      snk_data = 64'hDDDD_CCCC_BBBB_AAAA; snk_valid = 1'b1;
      step();
      snk_valid = 1'b0;
      step();
      chk("t5 restart valid", src_valid, 1);
      chk("t5 restart lane", src_data, 16'hAAAA);
      chk("t5 restart sop", src_sop, 1);
      drain(20);

      // counter wrap on the narrow-counter instance, then clear racing an accept
      clear();
      g = 0;
      snk_valid = 1'b1;
      while (m_words != 7 && g < 100) begin
         snk_data = {$urandom, $urandom};
         step(); g++;
         if (m_words == 7) snk_valid = 1'b0;
      end
      chk("t6 at max", words_in_s, 7);
      snk_valid = 1'b1;
      g = 0;
      step();
      while (!last_in && g < 20) begin
         step(); g++;
      end
      snk_valid = 1'b0;
      chk("t6 wrapped", words_in_s, 0);
      chk("t6 wide", words_in, 8);
      g = 0;
      while (!snk_ready && g < 20) begin
         step(); g++;
      end
      snk_valid = 1'b1; clr_counts = 1'b1;
      step();
      snk_valid = 1'b0; clr_counts = 1'b0;
      chk("t6 clr accept", last_in, 1);
      chk("t6 clr wins", words_in, 0);
      chk("t6 clr wins small", words_in_s, 0);
      drain(100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
